// File: rtl/leaf_stream_packetizer.sv
// Transmit side of the leaf-to-BFT stream link: packs user words into BFT packets,
// spending one credit per packet and refilling from freespace-update packets.
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user,
  output logic                     ack_user,
  input  logic                     resend,
  output logic                     configured,
  output logic [NUM_ADDR_BITS:0]   credits
);

  localparam int CRED_W = NUM_ADDR_BITS + 1;
  localparam int CRED_LIMIT = 1 << NUM_ADDR_BITS;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CRED_LIMIT);
  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;

  typedef enum logic [1:0] {UNCFG, RUN, STALL} state_t;

  state_t                     state_q, state_d;
  logic [CRED_W-1:0]          credits_q, credits_d;
  logic [NUM_ADDR_BITS-1:0]   addr_cnt_q, addr_cnt_d;
  logic [NUM_LEAF_BITS-1:0]   dest_leaf_q, dest_leaf_d;
  logic [NUM_PORT_BITS-1:0]   dest_port_q, dest_port_d;
  logic                       configured_q, configured_d;
  logic [PACKET_BITS-1:0]     dout_q, dout_d;
  logic                       send;

  // Credits only decrement while nonzero, so the sum never goes negative;
  // an update that would overshoot the remote buffer size is clipped.
  function automatic logic [CRED_W-1:0] next_credits(input logic [CRED_W-1:0] cur,
                                                     input logic dec, input logic inc);
    int sum;
    sum = int'(cur) - int'(dec) + (inc ? FREESPACE_UPDATE_SIZE : 0);
    if (sum > CRED_LIMIT) return CRED_MAX;
    return CRED_W'(sum);
  endfunction

  logic                     in_vld;
  logic [NUM_PORT_BITS-1:0] in_port;
  logic                     in_update;
  logic                     in_config;
  logic                     unused_in_bits;

  assign in_vld    = din_leaf_bft2interface[PACKET_BITS-1];
  assign in_port   = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign in_update = in_vld && (in_port == '0);
  assign in_config = in_vld && (in_port == NUM_PORT_BITS'(1));
  assign unused_in_bits = ^{din_leaf_bft2interface[PACKET_BITS-2 -: NUM_LEAF_BITS],
                            din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS],
                            din_leaf_bft2interface[PAYLOAD_BITS-1:NUM_LEAF_BITS+NUM_PORT_BITS]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= UNCFG;
    else       state_q <= state_d;
  end

  // Transitions look at next-cycle credits so a refill resumes sending immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNCFG:   if (in_config) state_d = (credits_d != '0) ? RUN : STALL;
      RUN:     if (credits_d == '0) state_d = STALL;
      STALL:   if (credits_d != '0) state_d = RUN;
      default: state_d = UNCFG;
    endcase
  end

  always_comb begin
    send     = (state_q == RUN) && vld_user && (credits_q != '0) && !resend;
    ack_user = send;
  end

  always_comb begin
    dest_leaf_d  = dest_leaf_q;
    dest_port_d  = dest_port_q;
    configured_d = configured_q;
    if (in_config) begin
      dest_leaf_d  = din_leaf_bft2interface[NUM_PORT_BITS +: NUM_LEAF_BITS];
      dest_port_d  = din_leaf_bft2interface[0 +: NUM_PORT_BITS];
      configured_d = 1'b1;
    end

    if (resend) begin
      addr_cnt_d = '0;
      credits_d  = CRED_MAX;
    end else begin
      addr_cnt_d = addr_cnt_q + {{(NUM_ADDR_BITS-1){1'b0}}, send};
      credits_d  = next_credits(credits_q, send, in_update);
    end

    dout_d = '0;
    if (send) dout_d = {1'b1, dest_leaf_q, dest_port_q, addr_cnt_q, din_user};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q    <= CRED_MAX;
      addr_cnt_q   <= '0;
      dest_leaf_q  <= '0;
      dest_port_q  <= '0;
      configured_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      credits_q    <= credits_d;
      addr_cnt_q   <= addr_cnt_d;
      dest_leaf_q  <= dest_leaf_d;
      dest_port_q  <= dest_port_d;
      configured_q <= configured_d;
      dout_q       <= dout_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign configured              = configured_q;
  assign credits                 = credits_q;

endmodule
